// File: rtl/adder_sched_pkg.sv
// Shared types, defaults and the round-robin grant function for adder_rr_scheduler.
package adder_sched_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_REQ = 4;
   localparam int MAX_REQ     = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t EXEC = 2'd1;
   localparam state_t RESP = 2'd2;

   // Scan upward from the requester after 'last', wrapping at num_req.
   // Returns 'last' when nothing is valid; callers gate on |valid anyway.
   function automatic int rr_next_grant(input logic [MAX_REQ-1:0] valid,
                                        input int                  last,
                                        input int                  num_req);
      int  grant;
      int  idx;
      logic found;
      grant = last;
      found = 1'b0;
      for (int i = 1; i <= MAX_REQ; i++) begin
         idx = (last + i) % num_req;
         if (i <= num_req && !found && valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/adder_core.sv
// Purely combinational WIDTH-bit adder with carry-out; the only datapath adder in the scheduler.
module adder_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one adder_core among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Optional build macro ADDER_SAT_EN: saturate rsp_sum to all ones when the addition carries out.
module adder_rr_scheduler
   import adder_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_carry,
   output logic                     busy
);

   state_t             state;
   state_t             state_nxt;
   logic [ID_W-1:0]    last_grant;
   logic [ID_W-1:0]    grant;
   logic [ID_W-1:0]    id_q;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   core_sum;
   logic [WIDTH-1:0]   sum_nxt;
   logic               core_carry;
   logic [MAX_REQ-1:0] valid_pad;
   logic               accept;

   assign valid_pad = MAX_REQ'(req_valid);
   assign grant     = ID_W'(rr_next_grant(valid_pad, int'(last_grant), NUM_REQ));

   // Reset is folded in so no grant is offered while rst is held.
   assign accept    = !rst && (state == IDLE) && (|req_valid);

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = EXEC;
         EXEC:                   state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   adder_core #(
      .WIDTH(WIDTH)
   ) u_adder_core (
      .a    (op_a),
      .b    (op_b),
      .sum  (core_sum),
      .carry(core_carry)
   );

`ifdef ADDER_SAT_EN
   assign sum_nxt = core_carry ? '1 : core_sum;
`else
   assign sum_nxt = core_sum;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         id_q       <= '0;
         op_a       <= '0;
         op_b       <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_a       <= req_a[int'(grant)*WIDTH +: WIDTH];
            op_b       <= req_b[int'(grant)*WIDTH +: WIDTH];
            id_q       <= grant;
            last_grant <= grant;
         end
      end
   end

   // Response registers load once in EXEC and then hold through any backpressure in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
      end else if (state == EXEC) begin
         rsp_id    <= id_q;
         rsp_sum   <= sum_nxt;
         rsp_carry <= core_carry;
      end
   end

endmodule
